// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger arbiter: op codes, response status
// codes, sequencer state encoding and default widths.
package atm_pkg;

   localparam int ATM_NUM_TERM    = 4;
   localparam int ATM_ACCT_W      = 17;
   localparam int ATM_AMT_W       = 19;
   localparam int ATM_TIMEOUT_CYC = 1000;

   // Terminal / ledger operation codes
   localparam logic [1:0] OP_BAL = 2'b00;
   localparam logic [1:0] OP_DEP = 2'b01;
   localparam logic [1:0] OP_WDR = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   // Response status codes; the low two bits come straight from the ledger
   localparam logic [2:0] ST_OK      = 3'b000;
   localparam logic [2:0] ST_NSF     = 3'b001;
   localparam logic [2:0] ST_BADACCT = 3'b010;
   localparam logic [2:0] ST_BADOP   = 3'b011;
   localparam logic [2:0] ST_TIMEOUT = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/atm_rr_picker.sv
// Combinational round-robin pick: first set request bit scanning upward
// from ptr+1 with wrap-around. The terminal at ptr itself is checked last.
module atm_rr_picker
   import atm_pkg::*;
#(
   parameter int NUM_TERM = ATM_NUM_TERM,
   parameter int IW       = 2
)(
   input  logic [NUM_TERM-1:0] req,
   input  logic [IW-1:0]       ptr,
   output logic [NUM_TERM-1:0] winner,
   output logic [IW-1:0]       index,
   output logic                any
);

   int          slot;
   logic [IW-1:0] slot_idx;

   // Scan NUM_TERM slots after the pointer; the first hit wins
   always_comb begin
      winner   = '0;
      index    = '0;
      any      = 1'b0;
      slot     = 0;
      slot_idx = '0;
      for (int i = 1; i <= NUM_TERM; i++) begin
         slot     = (int'(ptr) + i) % NUM_TERM;
         slot_idx = IW'(slot);
         if (!any && req[slot_idx]) begin
            any              = 1'b1;
            index            = slot_idx;
            winner[slot_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter sharing one single-port account ledger between
// NUM_TERM ATM terminal controllers. One transaction per grant; the grant
// is held from pick until the response cycle.
//
// Optional feature: define ATM_ARB_WDOG_EN to add a ledger watchdog that
// ends a BUSY transaction with a timeout status after TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | no grant; pick the next requester round-robin
// BUSY  | led_req held, waiting for led_ack (or watchdog expiry)
// RESP  | rsp_valid pulse to the granted terminal, grant still held
module atm_ledger_arbiter
   import atm_pkg::*;
#(
   parameter int NUM_TERM    = ATM_NUM_TERM,
   parameter int ACCT_W      = ATM_ACCT_W,
   parameter int AMT_W       = ATM_AMT_W,
   parameter int TIMEOUT_CYC = ATM_TIMEOUT_CYC
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_TERM-1:0]        req,
   input  logic [2*NUM_TERM-1:0]      req_op,
   input  logic [ACCT_W*NUM_TERM-1:0] req_acct,
   input  logic [AMT_W*NUM_TERM-1:0]  req_amt,
   output logic [NUM_TERM-1:0]        gnt,
   output logic                       rsp_valid,
   output logic [2:0]                 rsp_status,
   output logic [AMT_W-1:0]           rsp_balance,
   output logic                       led_req,
   output logic [1:0]                 led_op,
   output logic [ACCT_W-1:0]          led_acct,
   output logic [AMT_W-1:0]           led_amt,
   input  logic                       led_ack,
   input  logic [1:0]                 led_status,
   input  logic [AMT_W-1:0]           led_balance
);

   localparam int IW = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

   if (NUM_TERM < 2 || NUM_TERM > 8 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("atm_ledger_arbiter: NUM_TERM must be 2..8 and TIMEOUT_CYC >= 2");
   end

   state_t              state;
   logic [IW-1:0]       ptr;
   logic [NUM_TERM-1:0] win_oh;
   logic [IW-1:0]       win_idx;
   logic                win_any;
   logic [1:0]          sel_op;
   logic [ACCT_W-1:0]   sel_acct;
   logic [AMT_W-1:0]    sel_amt;

`ifdef ATM_ARB_WDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   logic [WW-1:0] wdog_cnt;
   logic          wdog_hit;

   assign wdog_hit = (wdog_cnt == WW'(TIMEOUT_CYC - 1));
`endif

   atm_rr_picker #(
      .NUM_TERM (NUM_TERM),
      .IW       (IW)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .winner (win_oh),
      .index  (win_idx),
      .any    (win_any)
   );

   // Route the winning terminal's transaction fields to the latch inputs
   always_comb begin
      sel_op   = req_op[win_idx*2 +: 2];
      sel_acct = req_acct[win_idx*ACCT_W +: ACCT_W];
      sel_amt  = req_amt[win_idx*AMT_W +: AMT_W];
   end

   // Sequencer: grant, forward to ledger, return response; all outputs flopped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= IW'(NUM_TERM - 1);
         gnt         <= '0;
         rsp_valid   <= 1'b0;
         rsp_status  <= ST_OK;
         rsp_balance <= '0;
         led_req     <= 1'b0;
         led_op      <= OP_BAL;
         led_acct    <= '0;
         led_amt     <= '0;
`ifdef ATM_ARB_WDOG_EN
         wdog_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  gnt      <= win_oh;
                  ptr      <= win_idx;
                  led_op   <= sel_op;
                  led_acct <= sel_acct;
                  led_amt  <= (sel_op == OP_BAL) ? '0 : sel_amt;
`ifdef ATM_ARB_WDOG_EN
                  wdog_cnt <= '0;
`endif
                  if (sel_op == OP_RSV) begin
                     // Reserved op is rejected locally; the ledger never sees it
                     rsp_valid   <= 1'b1;
                     rsp_status  <= ST_BADOP;
                     rsp_balance <= '0;
                     state       <= RESP;
                  end else begin
                     led_req <= 1'b1;
                     state   <= BUSY;
                  end
               end
            end

            BUSY: begin
               if (led_ack) begin
                  led_req     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_status  <= {1'b0, led_status};
                  rsp_balance <= led_balance;
                  state       <= RESP;
               end
`ifdef ATM_ARB_WDOG_EN
               else if (wdog_hit) begin
                  led_req     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_status  <= ST_TIMEOUT;
                  rsp_balance <= '0;
                  state       <= RESP;
               end else if (wdog_cnt != WW'(TIMEOUT_CYC)) begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
`endif
            end

            RESP: begin
               gnt       <= '0;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/atm_ledger_arbiter.md
Name: atm_ledger_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one single-port account-ledger interface between NUM_TERM ATM terminal controllers.
- Accepts one account transaction per grant: balance, deposit or withdraw.
- Forwards the transaction to the ledger, waits for completion and returns status/balance to the granted terminal.
- Sits between the per-terminal ATM FSMs and the ledger/account store.

Parameters:
NUM_TERM, 4, number of terminals (2..8)
ACCT_W, 17, account-number width
AMT_W, 19, amount/balance width
TIMEOUT_CYC, 1000, ledger watchdog limit in clk cycles (used only with ATM_ARB_WDOG_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_TERM  per-terminal request, level
req_op  in  2*NUM_TERM  per-terminal op: 00 balance, 01 deposit, 10 withdraw, 11 reserved
req_acct  in  ACCT_W*NUM_TERM  per-terminal account number
req_amt  in  AMT_W*NUM_TERM  per-terminal amount
gnt  out  NUM_TERM  one-hot grant, held for the whole transaction
rsp_valid  out  1  one-cycle response pulse to the granted terminal
rsp_status  out  3  000 OK, 001 insufficient funds, 010 bad account, 011 bad op, 100 timeout
rsp_balance  out  AMT_W  resulting balance; valid with rsp_valid
led_req  out  1  ledger request, held until led_ack
led_op  out  2  latched op
led_acct  out  ACCT_W  latched account
led_amt  out  AMT_W  latched amount; 0 for a balance op
led_ack  in  1  ledger completion pulse
led_status  in  2  ledger status (maps to rsp_status[1:0], rsp_status[2]=0)
led_balance  in  AMT_W  ledger balance, valid with led_ack

Behaviour:
- Reset (async): state IDLE; gnt, rsp_valid, rsp_status, rsp_balance, led_req, led_op, led_acct, led_amt all 0; rr pointer = NUM_TERM-1, so terminal 0 wins first.
- All outputs are registered.
- IDLE:
  - If any req bit is set, choose the first set bit scanning from pointer+1 with wrap-around.
  - Latch that terminal's op/acct/amt, set gnt one-hot, update pointer to the winner.
  - op≠11: go to BUSY with led_req=1.
  - op=11: go directly to RESP with status 011; led_req is never asserted.
  - Response to a request sampled at edge k is visible after edge k.
- BUSY:
  - led_req and the latched led_* fields are held stable.
  - On led_ack: capture led_status/led_balance, drop led_req, go to RESP.
  - Changes on req/req_op/req_acct/req_amt are ignored.
  - Requester dropping req mid-transaction does not abort it.
- RESP (one cycle):
  - rsp_valid=1 with status and balance; gnt still asserted this cycle.
  - Next edge: gnt=0, rsp_valid=0, go to IDLE.
  - The terminal must drop or refresh req in the cycle after rsp_valid. A still-high req re-competes at normal round-robin priority, so it is served last among active requesters.
- led_ack while not in BUSY: ignored.
- led_ack in the same cycle as led_req first rises: cannot occur (led_req is registered); acks are accepted from the first BUSY cycle onward.
- rsp_balance on a rejected op (011) = 0.
- No arithmetic is performed in the arbiter; amounts pass through unchanged at AMT_W bits.
- Reset mid-BUSY abandons the transaction; no response is generated.

Optional Feature:
- Macro ATM_ARB_WDOG_EN.
- Defined:
  - BUSY counts cycles from entry, 0-based, saturating at TIMEOUT_CYC.
  - If the count reaches TIMEOUT_CYC-1 without led_ack: drop led_req, go to RESP with status 100, rsp_balance 0.
  - A led_ack on that same cycle wins (normal response).
- Undefined: no counter; BUSY waits indefinitely for led_ack.

Decomposition:
- Package atm_pkg:
  - op codes OP_BAL/OP_DEP/OP_WDR/OP_RSV.
  - status codes ST_OK/ST_NSF/ST_BADACCT/ST_BADOP/ST_TIMEOUT.
  - FSM state enum {IDLE, BUSY, RESP}.
  - ACCT_W/AMT_W defaults.
- Sub-module: atm_rr_picker, combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, index, any.

Test Plan:
- Reset then req=0001, op=00, acct=17'h00123 -> next cycle gnt=0001, led_req=1, led_amt=0; led_ack with status 00, balance 19'd5000 -> rsp_valid one cycle, rsp_status=000, rsp_balance=5000, gnt=0 one cycle later.
- req=1111 held, ledger acks 3 cycles after each led_req -> grant order 0,1,2,3,0; never two gnt bits set.
- req=0100 with op=11 -> gnt=0100, rsp_valid with status 011 on the following cycle, led_req never 1.
- Withdraw 19'd700 on terminal 1 with ledger status 01 -> rsp_status=001; changing req_amt to 9 during BUSY leaves led_amt=700.
- With ATM_ARB_WDOG_EN and TIMEOUT_CYC=10, no ack -> led_req drops and rsp_status=100 exactly 10 cycles after entering BUSY; without the macro, led_req is still 1 after 2000 cycles.
- reset asserted mid-BUSY -> all outputs 0 immediately (asynchronous); after release, req=1010 -> gnt=0010 first.
